// File: rtl/piso_mux_sequencer_pkg.sv
// Shared constants for the parallel-in/serial-out select sequencer:
// state encoding, select range and word width.
package piso_mux_sequencer_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [SEL_W-1:0] SEL_LO = 3'd0;
    localparam logic [SEL_W-1:0] SEL_HI = 3'd7;

    function automatic logic [SEL_W-1:0] sel_start(input bit lsb_first);
        return lsb_first ? SEL_LO : SEL_HI;
    endfunction

    function automatic logic [SEL_W-1:0] sel_end(input bit lsb_first);
        return lsb_first ? SEL_HI : SEL_LO;
    endfunction

endpackage

// File: rtl/piso_mux_sequencer_if.sv
// Word-in / bit-out bundle of the sequencer. slave = the sequencer itself,
// master = whatever feeds words and consumes the serial stream.
interface piso_mux_sequencer_if #(
    parameter int CNT_W = 8
);
    import piso_mux_sequencer_pkg::*;

    // Both handshakes transfer on a rising edge where valid and ready are
    // high together; a valid side holds its data stable until that edge.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  sel;
    logic              ser_out;
    logic              ser_valid;
    logic              ser_ready;
    logic              sof;
    logic              eof;
    logic              busy;
    logic [CNT_W-1:0]  frame_cnt;

    modport slave (
        input  in_valid, in_data, ser_ready,
        output in_ready, sel, ser_out, ser_valid, sof, eof, busy, frame_cnt
    );

    modport master (
        output in_valid, in_data, ser_ready,
        input  in_ready, sel, ser_out, ser_valid, sof, eof, busy, frame_cnt
    );

endinterface

// File: rtl/piso_mux_sequencer_mux8to1.sv
// 8-to-1 gate-level multiplexer: one AND term per decoded select, OR-reduced.
module mux8to1 (
    input  logic [7:0] d_i,
    input  logic [2:0] sel_i,
    output logic       y_o
);

    logic [7:0] term;

    for (genvar i = 0; i < 8; i++) begin : g_term
        localparam logic [2:0] K = 3'(i);
        assign term[i] = d_i[i] & (sel_i == K);
    end

    assign y_o = |term;

endmodule

// File: rtl/piso_mux_sequencer.sv
// Holds an 8-bit word and walks the mux select across it, streaming one
// bit per accepted serial beat, with frame markers and a frame counter.
module piso_mux_sequencer
    import piso_mux_sequencer_pkg::*;
#(
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    piso_mux_sequencer_if.slave    bus
);

    localparam logic [SEL_W-1:0] START = sel_start(LSB_FIRST != 0);
    localparam logic [SEL_W-1:0] LAST  = sel_end(LSB_FIRST != 0);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic last, accept, step, in_ready, ser_valid;

    assign last   = (sel_q == LAST);
    assign accept = bus.in_valid & in_ready;
    assign step   = ser_valid & bus.ser_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= START;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    data_d  = bus.in_data;
                    sel_d   = START;
                end
            end
            SHIFT: begin
                if (step && !last) begin
                    sel_d = (LSB_FIRST != 0) ? sel_q + 3'd1 : sel_q - 3'd1;
                end else if (step) begin
                    cnt_d = cnt_q + 1'b1;
                    sel_d = START;
                    // A word accepted on the closing beat starts the next frame at once.
                    if (accept) begin
                        data_d = bus.in_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ser_valid = (state_q == SHIFT);
        in_ready  = (state_q == IDLE) | ((state_q == SHIFT) & last & bus.ser_ready);
    end

    mux8to1 u_mux (
        .d_i   (data_q),
        .sel_i (sel_q),
        .y_o   (bus.ser_out)
    );

    assign bus.in_ready  = in_ready;
    assign bus.ser_valid = ser_valid;
    assign bus.sel       = sel_q;
    assign bus.sof       = ser_valid & (sel_q == START);
    assign bus.eof       = ser_valid & last;
    assign bus.busy      = ser_valid;
    assign bus.frame_cnt = cnt_q;

endmodule

// File: doc/piso_mux_sequencer.md
Name: piso_mux_sequencer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the 8-to-1 gate-level multiplexer and drives its select lines.
- Accepts an 8-bit word over a valid/ready handshake, holds it, and steps the 3-bit select through all eight positions.
- Presents the selected bit as a serial stream with its own valid/ready handshake, plus start-of-frame and end-of-frame markers.
- Serves as the serial transmit front end for byte-wide datapaths.

Parameters:
- LSB_FIRST, 1: 1 = select counts 0→7 (bit 0 first); 0 = select counts 7→0.
- CNT_W, 8: width of the frame counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_data holds a word.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  8  parallel word.
- sel  output  3  current select value, drives the mux select.
- ser_out  output  1  selected bit, data_q[sel].
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  downstream accepts ser_out this cycle.
- sof  output  1  current bit is the first bit of its frame.
- eof  output  1  current bit is the last bit of its frame.
- busy  output  1  state is SHIFT.
- frame_cnt  output  CNT_W  count of fully transmitted words.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low on rst_n, sampled on the rising edge and dominant over all other inputs.
- Reset values: state=IDLE, data_q=0, sel=(LSB_FIRST ? 0 : 7), frame_cnt=0.
  - This gives ser_valid=0, sof=0, eof=0, busy=0, ser_out=0.
  - in_ready=1 from the first cycle after reset.
- States:
  - IDLE: ser_valid=0, in_ready=1.
  - SHIFT: ser_valid=1.
- Handshakes:
  - accept = in_valid & in_ready.
  - step = ser_valid & ser_ready.
  - last = (sel == 7) when LSB_FIRST=1, (sel == 0) when LSB_FIRST=0.
  - in_ready = IDLE | (SHIFT & last & ser_ready). This is combinational and allows back-to-back frames with no idle bubble.
- IDLE → SHIFT on accept:
  - data_q <= in_data.
  - sel <= start value (0, or 7 when LSB_FIRST=0).
  - First serial bit is valid in the cycle after the accept edge (1-cycle latency).
- In SHIFT, on step with !last: sel increments (LSB_FIRST=1) or decrements (LSB_FIRST=0).
- In SHIFT, on step with last:
  - frame_cnt increments, wrapping modulo 2^CNT_W.
  - If accept in the same cycle: load the new word, reset sel to its start value, stay in SHIFT.
  - Otherwise: go to IDLE. sel returns to its start value.
- Stalls: with ser_valid=1 and ser_ready=0, sel, data_q and ser_out hold stable. ser_valid never drops while in SHIFT.
- Markers: sof = SHIFT & (sel == start). eof = SHIFT & last. Both are combinational from registers.
- in_data is ignored whenever in_ready=0. A word presented mid-frame waits for its handshake.
- ser_out is a pure function of the registered data_q and sel, with no combinational path from ser_ready.
- Reset asserted mid-frame: the frame is abandoned with no partial eof. Outputs take reset values on the next edge and frame_cnt is cleared.
- A complete frame with ser_ready held at 1 takes exactly 8 cycles of ser_valid.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=1'b0, SHIFT=1'b1;
  - the select start/end constants;
  - the width constant 8.
- The natural sub-module is the existing mux8to1 gate-level multiplexer, instantiated with data_q and sel to produce ser_out.
- Counter and FSM live in the top.

Test Plan:
- Reset, then in_data=8'h55 with in_valid pulsed, ser_ready=1, LSB_FIRST=1 → ser_out 1,0,1,0,1,0,1,0 on 8 consecutive cycles. sof on the first bit, eof on the eighth, frame_cnt=1, then IDLE.
- LSB_FIRST=0 with 8'hA3 → ser_out 1,0,1,0,0,0,1,1 with sel 7 down to 0.
- Back-to-back 8'hFF then 8'h00 with in_valid held → 16 contiguous valid bits with no gap. in_ready is high only in the eof cycle; frame_cnt=2.
- ser_ready low for 3 cycles at sel=4 with 8'h10 → ser_out=1 and sel=4 held stable for all 4 cycles. Total frame length is 11 cycles.
- rst_n low at sel=5 mid-frame → next edge gives ser_valid=0, frame_cnt=0, in_ready=1. A following word 8'h81 serializes cleanly from bit 0.
- 256 consecutive frames with CNT_W=8 → frame_cnt wraps to 0.
